// File: rtl/lcd_hd44780_responder_if.sv
// LCD parallel bus between a controller (master) and a panel model (slave).
interface lcd_hd44780_responder_if;
    logic       LCD_EN;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA_IN;
    logic [7:0] LCD_DATA_OUT;
    logic       LCD_DATA_OE;

    modport master (
        output LCD_EN,
        output LCD_RS,
        output LCD_RW,
        output LCD_DATA_IN,
        input  LCD_DATA_OUT,
        input  LCD_DATA_OE
    );

    modport slave (
        input  LCD_EN,
        input  LCD_RS,
        input  LCD_RW,
        input  LCD_DATA_IN,
        output LCD_DATA_OUT,
        output LCD_DATA_OE
    );
endinterface

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible panel model: samples the LCD bus, decodes instructions,
// holds an 80-byte DDRAM and answers busy-flag / data reads.
module lcd_hd44780_responder #(
    parameter int unsigned BUSY_CYCLES  = 2000,
    parameter int unsigned CLEAR_CYCLES = 76000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lcd_hd44780_responder_if.slave lcd,
    input  logic [6:0]             dbg_addr,
    output logic [7:0]             dbg_data,
    output logic                   busy,
    output logic [6:0]             ac,
    output logic                   disp_on,
    output logic                   cursor_on,
    output logic                   blink_on,
    output logic                   entry_inc,
    output logic                   entry_shift,
    output logic                   func_8bit,
    output logic                   func_2line,
    output logic                   busy_viol
);
    localparam int unsigned DDRAM_DEPTH = 80;
    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CNT_MAX     = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DDRAM_DEPTH - 1);
    localparam logic [DATA_W-1:0] BLANK     = DATA_W'(8'h20);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   fill_idx;
    logic                cg_mode;
    logic                rd_rs;
    logic                oe_q;
    logic [DATA_W-1:0]   dout_q;

    logic                en_s1, en_s2, en_d;
    logic                rs_s1, rs_s2;
    logic                rw_s1, rw_s2;
    logic [DATA_W-1:0]   data_s1, data_s2;
    logic                en_rise, en_fall;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   ddram [DDRAM_DEPTH];

    assign lcd.LCD_DATA_OE  = oe_q;
    assign lcd.LCD_DATA_OUT = dout_q;

    assign en_rise = en_s2 & ~en_d;
    assign en_fall = en_d & ~en_s2;

    // Step an address through 0..79 with wrap in either direction.
    function automatic logic [ADDR_W-1:0] ac_step(input logic [ADDR_W-1:0] a, input logic inc);
        if (inc) begin
            return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
        end
        return (a == '0) ? LAST_ADDR : a - ADDR_W'(1);
    endfunction

    // Two-flop synchronisers for the asynchronous bus, plus EN history for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_s1   <= 1'b0;
            en_s2   <= 1'b0;
            en_d    <= 1'b0;
            rs_s1   <= 1'b0;
            rs_s2   <= 1'b0;
            rw_s1   <= 1'b0;
            rw_s2   <= 1'b0;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            en_s1   <= lcd.LCD_EN;
            en_s2   <= en_s1;
            en_d    <= en_s2;
            rs_s1   <= lcd.LCD_RS;
            rs_s2   <= rs_s1;
            rw_s1   <= lcd.LCD_RW;
            rw_s2   <= rw_s1;
            data_s1 <= lcd.LCD_DATA_IN;
            data_s2 <= data_s1;
        end
    end

    // DDRAM storage; writes are queued one cycle by the control block.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            ddram[mem_waddr] <= mem_wdata;
        end
    end

    // Registered debug read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= (dbg_addr <= LAST_ADDR) ? ddram[dbg_addr] : '0;
        end
    end

    // Control FSM: clear fill, busy timing, instruction/data decode and bus reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_CLEAR;
            busy        <= 1'b1;
            cnt         <= '0;
            fill_idx    <= '0;
            ac          <= '0;
            entry_inc   <= 1'b1;
            entry_shift <= 1'b0;
            disp_on     <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            func_8bit   <= 1'b1;
            func_2line  <= 1'b0;
            cg_mode     <= 1'b0;
            rd_rs       <= 1'b0;
            oe_q        <= 1'b0;
            dout_q      <= '0;
            busy_viol   <= 1'b0;
            mem_we      <= 1'b0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
        end else begin
            busy_viol <= 1'b0;
            mem_we    <= 1'b0;

            case (state)
                ST_CLEAR: begin
                    mem_we    <= 1'b1;
                    mem_waddr <= fill_idx;
                    mem_wdata <= BLANK;
                    if (fill_idx == LAST_ADDR) begin
                        fill_idx <= '0;
                        cnt      <= CNT_W'(CLEAR_CYCLES - DDRAM_DEPTH);
                        state    <= ST_BUSY;
                    end else begin
                        fill_idx <= fill_idx + ADDR_W'(1);
                    end
                end
                ST_BUSY: begin
                    if (cnt <= CNT_W'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase

            // Status reads track busy/ac live while the bus is driven.
            if (oe_q && !rd_rs) begin
                dout_q <= {busy, ac};
            end

            if (en_rise && rw_s2) begin
                oe_q   <= 1'b1;
                rd_rs  <= rs_s2;
                dout_q <= rs_s2 ? ddram[ac] : {busy, ac};
            end

            if (en_fall) begin
                oe_q <= 1'b0;
                if (rw_s2) begin
                    if (rs_s2) begin
                        ac <= ac_step(ac, entry_inc);
                    end
                end else if (state != ST_IDLE) begin
                    busy_viol <= 1'b1;
                end else begin
                    state <= ST_BUSY;
                    busy  <= 1'b1;
                    cnt   <= CNT_W'(BUSY_CYCLES);
                    if (rs_s2) begin
                        if (!cg_mode) begin
                            mem_we    <= 1'b1;
                            mem_waddr <= ac;
                            mem_wdata <= data_s2;
                            ac        <= ac_step(ac, entry_inc);
                        end
                    end else begin
                        casez (data_s2)
                            8'b1???_????: begin
                                cg_mode <= 1'b0;
                                ac      <= (data_s2[6:0] < ADDR_W'(DDRAM_DEPTH))
                                         ? data_s2[6:0]
                                         : data_s2[6:0] - ADDR_W'(DDRAM_DEPTH);
                            end
                            8'b01??_????: cg_mode <= 1'b1;
                            8'b001?_????: begin
                                func_8bit  <= data_s2[4];
                                func_2line <= data_s2[3];
                            end
                            8'b0001_????: begin
                                if (!data_s2[3]) begin
                                    ac <= ac_step(ac, data_s2[2]);
                                end
                            end
                            8'b0000_1???: begin
                                disp_on   <= data_s2[2];
                                cursor_on <= data_s2[1];
                                blink_on  <= data_s2[0];
                            end
                            8'b0000_01??: begin
                                entry_inc   <= data_s2[1];
                                entry_shift <= data_s2[0];
                            end
                            8'b0000_001?: begin
                                ac  <= '0;
                                cnt <= CNT_W'(CLEAR_CYCLES);
                            end
                            8'b0000_0001: begin
                                ac        <= '0;
                                entry_inc <= 1'b1;
                                fill_idx  <= '0;
                                state     <= ST_CLEAR;
                            end
                            default: begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Scoreboard bench for lcd_hd44780_responder: stimulus queues expectations,
// a monitor pops and compares them at the falling clock edge.
module tb_lcd_hd44780_responder;
    localparam int K_AC    = 0;
    localparam int K_BUSY  = 1;
    localparam int K_FLAGS = 2;
    localparam int K_DBG   = 3;
    localparam int K_BUS   = 4;
    localparam int K_OE    = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on;
    logic       entry_inc, entry_shift;
    logic       func_8bit, func_2line;
    logic       busy_viol;

    lcd_hd44780_responder_if lcd();

    lcd_hd44780_responder #(
        .BUSY_CYCLES  (4),
        .CLEAR_CYCLES (100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lcd         (lcd),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .busy        (busy),
        .ac          (ac),
        .disp_on     (disp_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .entry_inc   (entry_inc),
        .entry_shift (entry_shift),
        .func_8bit   (func_8bit),
        .func_2line  (func_2line),
        .busy_viol   (busy_viol)
    );

    always #5 clk = ~clk;

    string       chk_name_q[$];
    int          chk_kind_q[$];
    logic [15:0] chk_exp_q[$];
    string       rd_name_q[$];
    logic [7:0]  rd_exp_q[$];
    int          viol_expected = 0;
    int          viol_seen;
    int          tests;
    int          fails;
    bit          done = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares queued expectations against DUT outputs.
    initial begin
        string       nm;
        int          kd;
        logic [15:0] ex;
        logic [15:0] act;
        logic        oe_prev;
        tests     = 0;
        fails     = 0;
        viol_seen = 0;
        oe_prev   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (lcd.LCD_DATA_OE && !oe_prev) begin
                if (rd_exp_q.size() == 0) begin
                    check("unexpected read strobe", 16'(rd_exp_q.size()), 16'd1);
                end else begin
                    nm = rd_name_q.pop_front();
                    check(nm, 16'(lcd.LCD_DATA_OUT), 16'(rd_exp_q.pop_front()));
                end
            end
            oe_prev = lcd.LCD_DATA_OE;
            if (busy_viol) begin
                check("busy_viol pulse", 16'(viol_seen < viol_expected), 16'd1);
                viol_seen++;
            end
            if (chk_exp_q.size() != 0) begin
                nm = chk_name_q.pop_front();
                kd = chk_kind_q.pop_front();
                ex = chk_exp_q.pop_front();
                case (kd)
                    K_AC:    act = 16'(ac);
                    K_BUSY:  act = 16'(busy);
                    K_FLAGS: act = 16'({disp_on, cursor_on, blink_on, entry_inc,
                                        entry_shift, func_8bit, func_2line});
                    K_DBG:   act = 16'(dbg_data);
                    K_BUS:   act = 16'({lcd.LCD_DATA_OE, lcd.LCD_DATA_OUT});
                    default: act = 16'(lcd.LCD_DATA_OE);
                endcase
                check(nm, act, ex);
            end
        end
        check("reads left unobserved", 16'(rd_exp_q.size()), 16'd0);
        check("busy_viol pulses seen", 16'(viol_seen), 16'(viol_expected));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic push(input string name, input int kind, input logic [15:0] exp);
        chk_name_q.push_back(name);
        chk_kind_q.push_back(kind);
        chk_exp_q.push_back(exp);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_dbg(input logic [6:0] addr, input logic [7:0] exp, input string name);
        dbg_addr = addr;
        repeat (2) @(posedge clk);
        push(name, K_DBG, 16'(exp));
    endtask

    // EN pulse for a write; returns two cycles after EN falls.
    task automatic wr(input logic rs, input logic [7:0] d);
        lcd.LCD_RS      = rs;
        lcd.LCD_RW      = 1'b0;
        lcd.LCD_DATA_IN = d;
        @(posedge clk); #1 lcd.LCD_EN = 1'b1;
        repeat (3) @(posedge clk); #1 lcd.LCD_EN = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    // Write and confirm busy is high for exactly four cycles.
    task automatic wr_chk(input logic rs, input logic [7:0] d);
        wr(rs, d);
        @(posedge clk);
        push($sformatf("busy first cycle after 0x%02h", d), K_BUSY, 16'd1);
        repeat (3) @(posedge clk);
        push($sformatf("busy fourth cycle after 0x%02h", d), K_BUSY, 16'd1);
        @(posedge clk);
        push($sformatf("busy drop after 0x%02h", d), K_BUSY, 16'd0);
    endtask

    task automatic rd(input logic rs, input logic [7:0] exp, input string name);
        rd_name_q.push_back(name);
        rd_exp_q.push_back(exp);
        lcd.LCD_RS = rs;
        lcd.LCD_RW = 1'b1;
        @(posedge clk); #1 lcd.LCD_EN = 1'b1;
        repeat (4) @(posedge clk); #1 lcd.LCD_EN = 1'b0;
        repeat (3) @(posedge clk); #1 lcd.LCD_RW = 1'b0;
        push({name, " oe released"}, K_OE, 16'd0);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400 && busy; i++) begin
            @(posedge clk); #1;
        end
        push(name, K_BUSY, 16'd0);
    endtask

    // Release reset and check the 100-cycle power-on clear.
    task automatic release_and_check(input string tag);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (99) @(posedge clk);
        push({tag, " busy at cycle 99"}, K_BUSY, 16'd1);
        @(posedge clk);
        push({tag, " busy clear at cycle 100"}, K_BUSY, 16'd0);
    endtask

    // Directed stimulus.
    initial begin
        rst_n           = 1'b0;
        lcd.LCD_EN      = 1'b0;
        lcd.LCD_RS      = 1'b0;
        lcd.LCD_RW      = 1'b0;
        lcd.LCD_DATA_IN = 8'h00;
        dbg_addr        = 7'd0;

        repeat (3) @(posedge clk); #1;
        push("reset ac", K_AC, 16'd0);
        push("reset flags", K_FLAGS, 16'h000A);
        push("reset bus", K_BUS, 16'h0000);
        push("reset busy", K_BUSY, 16'd1);
        release_and_check("por");

        chk_dbg(7'd0,  8'h20, "blank addr 0");
        chk_dbg(7'd40, 8'h20, "blank addr 40");
        chk_dbg(7'd79, 8'h20, "blank addr 79");
        push("ac after clear", K_AC, 16'd0);

        wr_chk(1'b0, 8'h38);
        push("flags after 0x38", K_FLAGS, 16'h000B);
        wr_chk(1'b0, 8'h0F);
        push("flags after 0x0F", K_FLAGS, 16'h007B);
        wr_chk(1'b0, 8'h06);
        push("flags after 0x06", K_FLAGS, 16'h007B);

        wr_chk(1'b1, 8'h48);
        wr_chk(1'b1, 8'h69);
        chk_dbg(7'd0, 8'h48, "ddram[0] H");
        chk_dbg(7'd1, 8'h69, "ddram[1] i");
        push("ac after Hi", K_AC, 16'd2);

        wr_chk(1'b0, 8'h80);
        push("ac set 0", K_AC, 16'd0);
        rd(1'b1, 8'h48, "data read ddram[0]");
        push("ac step after data read", K_AC, 16'd1);

        wr_chk(1'b0, 8'hCF);
        push("ac set 79", K_AC, 16'd79);
        wr_chk(1'b1, 8'h41);
        chk_dbg(7'd79, 8'h41, "ddram[79] A");
        push("ac wrap up", K_AC, 16'd0);

        wr_chk(1'b0, 8'h04);
        push("flags after 0x04", K_FLAGS, 16'h0073);
        wr_chk(1'b1, 8'h5A);
        chk_dbg(7'd0, 8'h5A, "ddram[0] decrement write");
        push("ac wrap down", K_AC, 16'd79);

        wr_chk(1'b0, 8'hD4);
        push("ac addr 84 folds to 4", K_AC, 16'd4);
        wr_chk(1'b0, 8'h80);
        wr_chk(1'b0, 8'h10);
        push("cursor left wraps", K_AC, 16'd79);
        wr_chk(1'b0, 8'h14);
        push("cursor right wraps", K_AC, 16'd0);
        wr_chk(1'b0, 8'h1C);
        push("display shift keeps ac", K_AC, 16'd0);

        wr(1'b0, 8'h00);
        @(posedge clk);
        push("noop stays idle", K_BUSY, 16'd0);
        push("noop flags", K_FLAGS, 16'h0073);

        wr_chk(1'b0, 8'h85);
        push("ac set 5", K_AC, 16'd5);
        wr(1'b0, 8'h02);
        viol_expected++;
        wr(1'b1, 8'h55);
        push("ac after dropped write", K_AC, 16'd0);
        chk_dbg(7'd0, 8'h5A, "ddram[0] after dropped write");
        rd(1'b0, 8'h80, "status read while busy");
        wait_idle("home completes");

        wr_chk(1'b0, 8'h40);
        wr_chk(1'b1, 8'h77);
        chk_dbg(7'd0, 8'h5A, "cgram data leaves ddram");
        push("cgram data keeps ac", K_AC, 16'd0);
        wr_chk(1'b0, 8'h80);

        wr(1'b0, 8'h01);
        repeat (31) @(posedge clk); #1 rst_n = 1'b0;
        push("mid-clear reset ac", K_AC, 16'd0);
        push("mid-clear reset flags", K_FLAGS, 16'h000A);
        push("mid-clear reset bus", K_BUS, 16'h0000);
        push("mid-clear reset busy", K_BUSY, 16'd1);
        release_and_check("restart");
        chk_dbg(7'd79, 8'h20, "restart blank addr 79");
        chk_dbg(7'd50, 8'h20, "restart blank addr 50");
        chk_dbg(7'd0,  8'h20, "restart blank addr 0");
        push("restart ac", K_AC, 16'd0);

        done = 1'b1;
    end
endmodule
